// File: rtl/jtframe_dump_trig_pkg.sv
// Shared types and default widths for the frame dump trigger.
// No logic; state encoding matches the st output values.
// Imported by the top-level trigger.
package jtframe_dump_pkg;

  localparam int DEF_CW = 32;
  localparam int DEF_LW = 16;

  typedef enum logic [1:0] {
    WAIT_DL = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } dump_st_t;

endpackage

// File: rtl/jtframe_dump_trig_edge.sv
// Falling-edge detector for a clk-synchronous strobe (VS, HS, LVBL...).
// Latency: fall is combinational from the live input and a one-cycle delayed copy.
// Reset value of the delayed copy is high, so a low input right after reset reads as an edge.
module jtframe_edge_fall (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic fall
);

  logic sig_l;

  // delayed copy of the input for edge comparison
  always_ff @(posedge clk) begin
    if (!rst_n) sig_l <= 1'b1;
    else        sig_l <= sig;
  end

  assign fall = sig_l & ~sig;

endmodule

// File: rtl/jtframe_dump_trig.sv
// Frame counter and capture-window generator for dump/debug gating.
// Latency: every output is registered; reactions appear the cycle after the VS fall.
// No backpressure: downloading aborts any state and holds the frame count at zero.
module jtframe_dump_trig
  import jtframe_dump_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int LW = DEF_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          downloading,
  input  logic [CW-1:0] start_frame,
  input  logic [LW-1:0] dump_len,
  input  logic          rearm,
  output logic [CW-1:0] frame_cnt,
  output logic          dump_en,
  output logic          dump_start,
  output logic          dump_stop,
  output logic [1:0]    st
);

  logic fall;

  dump_st_t      st_q,       st_nx;
  logic          en_nx,      start_nx,  stop_nx;
  logic [LW-1:0] len_cnt,    len_cnt_nx;
  logic [CW-1:0] start_lat,  start_lat_nx;
  logic [LW-1:0] len_lat,    len_lat_nx;
  logic [LW-1:0] len_inc;

  jtframe_edge_fall u_vs_fall (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (vs),
    .fall  (fall)
  );

  // frame counter: held at zero during download, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n)           frame_cnt <= '0;
    else if (downloading) frame_cnt <= '0;
    else if (fall)        frame_cnt <= frame_cnt + CW'(1);
  end

  assign len_inc = len_cnt + LW'(1);

  // next-state and next-output decisions; abort by download overrides everything
  always_comb begin
    st_nx        = st_q;
    en_nx        = dump_en;
    start_nx     = 1'b0;
    stop_nx      = 1'b0;
    len_cnt_nx   = len_cnt;
    start_lat_nx = start_lat;
    len_lat_nx   = len_lat;
    if (downloading) begin
      st_nx = WAIT_DL;
      en_nx = 1'b0;
      if (st_q == CAPTURE) stop_nx = 1'b1;
    end else begin
      case (st_q)
        WAIT_DL: begin
          st_nx        = ARMED;
          start_lat_nx = start_frame;
          len_lat_nx   = dump_len;
        end
        ARMED: begin
          if (fall && frame_cnt == start_lat) begin
            st_nx      = CAPTURE;
            en_nx      = 1'b1;
            start_nx   = 1'b1;
            len_cnt_nx = '0;
          end
        end
        CAPTURE: begin
          if (fall) begin
            // saturate so an unbounded capture never wraps the length count
            if (len_cnt != '1) len_cnt_nx = len_inc;
            if (len_lat != '0 && len_inc == len_lat) begin
              st_nx   = DONE;
              en_nx   = 1'b0;
              stop_nx = 1'b1;
            end
          end
        end
        DONE: begin
          en_nx = 1'b0;
          // rearm takes priority over a coincident fall; that frame cannot trigger
          if (rearm) begin
            st_nx        = ARMED;
            start_lat_nx = start_frame;
            len_lat_nx   = dump_len;
          end
        end
        default: st_nx = WAIT_DL;
      endcase
    end
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= WAIT_DL;
      dump_en    <= 1'b0;
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
      len_cnt    <= '0;
      start_lat  <= '0;
      len_lat    <= '0;
    end else begin
      st_q       <= st_nx;
      dump_en    <= en_nx;
      dump_start <= start_nx;
      dump_stop  <= stop_nx;
      len_cnt    <= len_cnt_nx;
      start_lat  <= start_lat_nx;
      len_lat    <= len_lat_nx;
    end
  end

  assign st = st_q;

endmodule

// File: tb/tb_jtframe_dump_trig.sv
// Directed bench for jtframe_dump_trig: a default-width instance and a CW=4 instance for wrap.
module tb_jtframe_dump_trig;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs, downloading, rearm;
  logic [31:0] start_frame;
  logic [15:0] dump_len;
  logic [31:0] frame_cnt;
  logic        dump_en, dump_start, dump_stop;
  logic [1:0]  st;

  logic        w_vs, w_dl, w_rearm;
  logic [3:0]  w_start, w_len, w_cnt;
  logic        w_en, w_start_p, w_stop;
  logic [1:0]  w_st;

  int checks   = 0;
  int failures = 0;
  int starts;

  always #5 clk = ~clk;

  jtframe_dump_trig dut (
    .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
    .start_frame(start_frame), .dump_len(dump_len), .rearm(rearm),
    .frame_cnt(frame_cnt), .dump_en(dump_en), .dump_start(dump_start),
    .dump_stop(dump_stop), .st(st)
  );

  jtframe_dump_trig #(.CW(4), .LW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .vs(w_vs), .downloading(w_dl),
    .start_frame(w_start), .dump_len(w_len), .rearm(w_rearm),
    .frame_cnt(w_cnt), .dump_en(w_en), .dump_start(w_start_p),
    .dump_stop(w_stop), .st(w_st)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one VS frame: high for a cycle, then low; returns just after the falling edge is taken
  task automatic do_fall();
    vs = 1'b1; step();
    vs = 1'b0; step();
  endtask

  task automatic w_fall();
    w_vs = 1'b1; step();
    w_vs = 1'b0; step();
  endtask

  initial begin
    rst_n = 1'b0; downloading = 1'b1; vs = 1'b1; rearm = 1'b0;
    start_frame = 32'd3; dump_len = 16'd2;
    w_vs = 1'b1; w_dl = 1'b0; w_rearm = 1'b0; w_start = 4'd15; w_len = 4'd1;
    step(); step();
    chk("rst_cnt",   frame_cnt,  0);
    chk("rst_en",    dump_en,    0);
    chk("rst_start", dump_start, 0);
    chk("rst_stop",  dump_stop,  0);
    chk("rst_st",    st,         0);
    rst_n = 1'b1;

    // VS keeps running during download; count must stay at zero
    for (int i = 0; i < 50; i++) begin
      do_fall();
      chk("dl_hold_cnt", frame_cnt, 0);
    end
    chk("dl_st", st, 0);

    downloading = 1'b0;
    step();
    chk("armed_st",  st,        1);
    chk("armed_cnt", frame_cnt, 0);

    do_fall(); chk("cnt1", frame_cnt, 1);
    do_fall(); chk("cnt2", frame_cnt, 2);
    do_fall(); chk("cnt3", frame_cnt, 3); chk("pre_trig_en", dump_en, 0);
    do_fall();
    chk("trig_cnt",   frame_cnt,  4);
    chk("trig_en",    dump_en,    1);
    chk("trig_start", dump_start, 1);
    chk("trig_st",    st,         2);
    step();
    chk("start_pulse_end", dump_start, 0);
    chk("en_hold",         dump_en,    1);
    do_fall();
    chk("cnt5",     frame_cnt, 5);
    chk("en_frame2", dump_en,  1);
    chk("no_stop",  dump_stop, 0);
    do_fall();
    chk("stop_cnt",   frame_cnt,  6);
    chk("stop_en",    dump_en,    0);
    chk("stop_pulse", dump_stop,  1);
    chk("stop_nostart", dump_start, 0);
    chk("done_st",    st,         3);
    step();
    chk("stop_pulse_end", dump_stop, 0);

    // rearm from DONE with a new start frame and a one-frame window
    start_frame = 32'd10; dump_len = 16'd1;
    rearm = 1'b1; step(); rearm = 1'b0;
    chk("rearm_st", st, 1);
    for (int i = 0; i < 4; i++) do_fall();
    chk("cnt10",      frame_cnt, 10);
    chk("cnt10_en",   dump_en,   0);
    do_fall();
    chk("rearm_trig_cnt",   frame_cnt,  11);
    chk("rearm_trig_start", dump_start, 1);
    chk("rearm_trig_st",    st,         2);
    rearm = 1'b1; step(); rearm = 1'b0;
    chk("rearm_ignored", st, 2);
    do_fall();
    chk("len1_cnt",  frame_cnt, 12);
    chk("len1_stop", dump_stop, 1);
    chk("len1_st",   st,        3);
    chk("len1_en",   dump_en,   0);

    // download while in DONE: back to WAIT_DL without a stop pulse
    downloading = 1'b1; start_frame = 32'd1; dump_len = 16'd0;
    step();
    chk("abort_done_st",   st,        0);
    chk("abort_done_cnt",  frame_cnt, 0);
    chk("abort_done_stop", dump_stop, 0);
    downloading = 1'b0;
    step();
    chk("unb_armed", st, 1);
    do_fall(); chk("unb_cnt1", frame_cnt, 1); chk("unb_en0", dump_en, 0);
    do_fall(); chk("unb_cnt2", frame_cnt, 2); chk("unb_start", dump_start, 1);
    for (int i = 0; i < 50; i++) begin
      do_fall();
      chk("unb_en", dump_en, 1);
    end
    // abort coinciding with a fall
    vs = 1'b1; step();
    vs = 1'b0; downloading = 1'b1; step();
    chk("abort_stop",  dump_stop,  1);
    chk("abort_start", dump_start, 0);
    chk("abort_en",    dump_en,    0);
    chk("abort_st",    st,         0);
    chk("abort_cnt",   frame_cnt,  0);
    step();
    chk("abort_stop_end", dump_stop, 0);

    // start_frame 0 triggers on the first fall, then reset mid-capture
    downloading = 1'b0; vs = 1'b1; start_frame = 32'd0; dump_len = 16'd0;
    step();
    chk("s0_armed", st, 1);
    do_fall();
    chk("s0_cnt",   frame_cnt,  1);
    chk("s0_en",    dump_en,    1);
    chk("s0_start", dump_start, 1);
    vs = 1'b1;
    rst_n = 1'b0; step();
    chk("mrst_cnt",   frame_cnt,  0);
    chk("mrst_en",    dump_en,    0);
    chk("mrst_start", dump_start, 0);
    chk("mrst_stop",  dump_stop,  0);
    chk("mrst_st",    st,         0);
    rst_n = 1'b1;

    // 4-bit frame counter wrap on the second instance, start at 15, one frame long
    step();
    chk("w_armed", w_st, 1);
    for (int k = 1; k <= 17; k++) begin
      w_fall();
      chk("w_cnt", w_cnt, k % 16);
      if (k == 15) chk("w_pretrig_en", w_en, 0);
      if (k == 16) chk("w_trig_start", w_start_p, 1);
    end
    chk("w_stop", w_stop, 1);
    chk("w_done", w_st,   3);
    w_rearm = 1'b1; step(); w_rearm = 1'b0;
    chk("w_rearm_st", w_st, 1);
    starts = 0;
    for (int k = 0; k < 32; k++) begin
      w_fall();
      starts += int'(w_start_p);
    end
    chk("w_one_trigger", starts, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtframe_dump_trig.md
Name: jtframe_dump_trig

Overview:
- Synthesizable generator for the frame-based capture-window signals that simulation dump and debug logic consume.
- Counts frames on falling edges of the game's vertical sync, held at zero while the ROM download is active.
- Raises a dump-enable window starting at a programmable frame, for a programmable number of frames.
- Sits in the game top next to the video timing. Drives frame_cnt to the test harness and to on-chip capture logic (signal tap gating, LED).

Parameters:
- CW, 32, frame counter width.
- LW, 16, capture length counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- vs  in  1  vertical sync, synchronous to clk; frame boundary is its falling edge
- downloading  in  1  ROM download active; clears and holds the frame count
- start_frame  in  CW  frame number at which capture begins
- dump_len  in  LW  frames to capture; 0 means unbounded
- rearm  in  1  one-cycle pulse that returns DONE to ARMED
- frame_cnt  out  CW  frames elapsed since download end
- dump_en  out  1  capture window active
- dump_start  out  1  one-cycle pulse when the window opens
- dump_stop  out  1  one-cycle pulse when the window closes or is aborted
- st  out  2  state: 0 WAIT_DL, 1 ARMED, 2 CAPTURE, 3 DONE

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low.
- All outputs are registered.
- Reset values: frame_cnt=0, dump_en=0, dump_start=0, dump_stop=0, st=WAIT_DL, vs_l=1, len_cnt=0.
- Edge detect: vs_l <= vs; fall = vs_l & ~vs.
- frame_cnt:
  - Cleared to 0 every cycle downloading=1.
  - Otherwise +1 on fall; wraps from all-ones to 0.
- States:
  - WAIT_DL: go to ARMED on the first cycle downloading=0; latch start_frame and dump_len on that transition.
  - ARMED: on fall with frame_cnt==latched start (value before the increment, same cycle as the fall), go to CAPTURE. Set dump_en=1 and pulse dump_start. Both are visible the cycle after fall. Load len_cnt=0.
  - CAPTURE, on each fall:
    - len_cnt increments.
    - If latched len != 0 and len_cnt+1 == latched len: go to DONE, set dump_en=0, pulse dump_stop.
    - If latched len == 0, stay until abort.
  - DONE: dump_en=0. On rearm, go to ARMED and re-latch start_frame/dump_len. rearm is ignored in every other state.
- Abort: downloading=1 in any state forces WAIT_DL next cycle.
  - From CAPTURE this also clears dump_en and pulses dump_stop.
  - No dump_start pulse is issued in that cycle even if fall coincides.
- Simultaneous rearm and fall in DONE: rearm wins. The fall is not evaluated for triggering in that cycle, so a match on exactly that frame is missed (documented limitation).
- start_frame==0: triggers at the first fall after download end, when frame_cnt goes 0→1.
- len_cnt saturates at all-ones when len=0, so it never wraps.
- dump_start and dump_stop are never high in the same cycle.
- Reset asserted mid-capture: all outputs return to their reset values next cycle; no dump_stop pulse.

Decomposition:
- Shared package jtframe_dump_pkg:
  - state enum (WAIT_DL/ARMED/CAPTURE/DONE, 2 bits)
  - default CW/LW constants
- One sub-module, jtframe_edge_fall: registered falling-edge detector with sync active-low reset, reset value high. It is reusable for HS/LVBL.
- Remaining logic (counters plus state machine) stays in the top.

Test Plan:
- Download then count: downloading=1 for 100 cycles, then 5 vs pulses → frame_cnt 0 throughout download, then 1..5. st=ARMED one cycle after downloading falls.
- Trigger and length: start_frame=3, dump_len=2 → dump_start the cycle after the fall where frame_cnt==3. dump_en high for exactly 2 frames. dump_stop at the fall with frame_cnt==5. st=DONE.
- Unbounded: dump_len=0, start=1 → dump_en stays high for 50 frames. Then raising downloading gives dump_stop next cycle, dump_en=0, st=WAIT_DL, frame_cnt=0.
- Rearm: after DONE, set start=10 and pulse rearm → st=ARMED. Trigger at frame_cnt==10. Rearm pulsed during CAPTURE has no effect.
- Wrap: with CW=4, 17 falls → frame_cnt sequence 15→0→1. start=15 triggers exactly once per wrap when rearmed.
- Reset mid-capture: rst_n=0 for 1 cycle while dump_en=1 → all outputs 0 next cycle, dump_stop stays 0, st=WAIT_DL.
